mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one registered output channel among N requesters by steering an N:1 data mux. It follows the team's 2:1 mux primitives and provides their sequencing layer: it chooses the select, holds it for multi-beat packets, and registers the muxed beat toward a single consumer with valid/ready flow control.

## Interface
Parameters:
- N, 4, number of requesters (N >= 2, power of two not required)
- DW, 8, data width per requester
- IW (localparam), $clog2(N), width of source index

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_req  input  N  requester i has a beat available; held until granted
- i_last  input  N  beat of requester i is the final beat of its packet
- i_data  input  N*DW  requester i data at bits [i*DW +: DW]
- o_gnt  output  N  one-hot grant; beat of requester i accepted at this rising edge
- o_valid  output  1  output register holds a beat
- o_data  output  DW  registered beat data
- o_src  output  IW  index of the requester that supplied o_data
- o_last  output  1  registered copy of the winner's i_last
- i_ready  input  1  consumer accepts the o_data beat this cycle

## Operation
- load = ~o_valid | i_ready. A beat is taken only when load = 1.
- State machine with two states, ARB and LOCK. Registers: ptr (IW bits), owner (IW bits).
- ARB state:
  - winner = first index k in ptr, ptr+1, …, N-1, 0, …, ptr-1 with i_req[k] = 1.
  - If load = 1 and any i_req is high, then o_gnt[winner] = 1 and the output register captures the beat.
  - If i_last[winner] = 1: stay in ARB and set ptr <= (winner+1) mod N.
  - Else: go to LOCK and set owner <= winner.
- LOCK state:
  - Only owner is eligible. Other requests are ignored.
  - o_gnt[owner] = load & i_req[owner].
  - On a granted beat with i_last[owner] = 1: go to ARB and set ptr <= (owner+1) mod N.
  - If owner drops i_req, the controller stalls in LOCK. No other requester is served.
- o_gnt is combinational from state and inputs, and is all-zero when load = 0 or i_rst = 1. At most one bit is ever set.
- Output register on load:
  - With a grant: o_valid <= 1; o_data, o_src and o_last take the winner's values.
  - Without a grant: o_valid <= 0; o_data, o_src and o_last hold their values.
- When o_valid = 1 and i_ready = 0, o_data, o_src and o_last hold stable.
- ptr wraps from N-1 to 0. The mod-N increment must be correct for non-power-of-two N.

## Timing
- Reset (synchronous, i_rst high at an edge): state = ARB, ptr = 0, owner = 0, o_valid = 0, o_data = 0, o_src = 0, o_last = 0. o_gnt = 0 while i_rst is high.
- Latency: a grant at edge t gives o_valid = 1 with that beat from edge t onward (1 cycle, request to output).
- Throughput: 1 beat per cycle while i_ready = 1 and requests are present. There is no bubble on arbitration or on a packet boundary.
- Simultaneous events:
  - A consumer accept and a new grant in the same cycle are allowed; the register is replaced.
  - A last beat and re-arbitration do not coincide; the next winner is chosen the cycle after the last beat is granted.
- Reset during a packet returns to ARB with ptr = 0. The in-flight output beat is discarded. The owner's remaining beats are re-arbitrated as a new packet.

## Test plan
- Reset: hold i_rst 2 cycles with all i_req = 1. Required: o_gnt = 0, o_valid = 0, o_data = 0, o_src = 0, o_last = 0, and state ARB on release.
- Fair rotation, N = 4, all single-beat:
  - Stimulus: i_req = 4'b1111, i_last = 4'b1111, i_ready = 1, i_data[i] = 8'hA0+i.
  - Required: grants on 0,1,2,3,0 in consecutive cycles; o_src = 0,1,2,3,0 one cycle later; o_data = A0,A1,A2,A3,A0.
- Backpressure:
  - Stimulus: after the first beat, i_ready = 0 for 3 cycles.
  - Required: o_gnt = 0; o_valid, o_data and o_src stable for 3 cycles; rotation resumes on the same winner order when i_ready = 1.
- Packet lock:
  - Stimulus: requester 1 sends a 3-beat packet (i_last only on beat 3) while requesters 0 and 2 hold single-beat requests, ptr = 1.
  - Required: grant sequence 1,1,1,2,0. o_last = 1 only on the third beat from source 1.
- Wrap and idle:
  - Stimulus: after a grant to requester 3, assert only i_req[0] and i_req[3].
  - Required: requester 0 is granted first. With no requests and i_ready = 1, o_valid drops to 0 the next cycle.
- Reset mid-packet:
  - Stimulus: assert i_rst after beat 2 of a 4-beat packet from requester 2.
  - Required: o_valid = 0 next cycle, state ARB, ptr = 0. If requesters 0 and 2 then request, requester 0 is granted first.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 arbiter with multi-beat packet lock, steering a data mux into
// a registered valid/ready output stage.
module mux_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8,
  localparam int IW = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_req,
  input  logic [N-1:0]    i_last,
  input  logic [N*DW-1:0] i_data,
  output logic [N-1:0]    o_gnt,
  output logic            o_valid,
  output logic [DW-1:0]   o_data,
  output logic [IW-1:0]   o_src,
  output logic            o_last,
  input  logic            i_ready
);

  typedef enum logic {ARB, LOCK} state_e;

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] owner_q;
  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [IW-1:0] src_q;
  logic          last_q;

  logic          load;
  logic          any_req;
  logic          take;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] sel_idx;
  logic [DW-1:0] sel_data;
  logic          sel_last;
  logic [N-1:0]  gnt;

  // Modulo-N add; N need not be a power of two, so bit truncation is not enough.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    any_req = 1'b0;
    win_idx = ptr_q;
    for (int off = N - 1; off >= 0; off--) begin
      if (i_req[wrap_add(ptr_q, off)]) begin
        any_req = 1'b1;
        win_idx = wrap_add(ptr_q, off);
      end
    end
  end

  assign load     = ~valid_q | i_ready;
  assign sel_idx  = (state_q == LOCK) ? owner_q : win_idx;
  assign sel_data = i_data[int'(sel_idx)*DW +: DW];
  assign sel_last = i_last[sel_idx];

  always_comb begin
    gnt = '0;
    if (!i_rst && load) begin
      if (state_q == ARB) gnt[sel_idx] = any_req;
      else                gnt[sel_idx] = i_req[sel_idx];
    end
  end

  assign take = |gnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      if (load) begin
        valid_q <= take;
        if (take) begin
          data_q <= sel_data;
          src_q  <= sel_idx;
          last_q <= sel_last;
        end
      end
      if (take) begin
        if (state_q == ARB) begin
          if (sel_last) begin
            ptr_q <= wrap_add(sel_idx, 1);
          end else begin
            state_q <= LOCK;
            owner_q <= sel_idx;
          end
        end else if (sel_last) begin
          state_q <= ARB;
          ptr_q   <= wrap_add(owner_q, 1);
        end
      end
    end
  end

  assign o_gnt   = gnt;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_src   = src_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scenario bench for mux_rr_arbiter: expected beats are queued at grant time and
// compared against the registered output one edge later.
module tb_mux_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            ready;
  logic [N-1:0]    req, last, gnt;
  logic [N*DW-1:0] data;
  logic            valid, olast;
  logic [DW-1:0]   odata;
  logic [IW-1:0]   src;

  logic [2:0]      req3, last3, gnt3;
  logic [3*DW-1:0] data3;
  logic            valid3, olast3;
  logic [DW-1:0]   odata3;
  logic [1:0]      src3;

  typedef struct packed {
    logic [IW-1:0] src;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t sb[$];
  beat_t held;
  int total = 0;
  int bad   = 0;

  mux_rr_arbiter #(.N(N), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_last(last), .i_data(data),
    .o_gnt(gnt), .o_valid(valid), .o_data(odata), .o_src(src), .o_last(olast),
    .i_ready(ready)
  );

  mux_rr_arbiter #(.N(3), .DW(DW)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_req(req3), .i_last(last3), .i_data(data3),
    .o_gnt(gnt3), .o_valid(valid3), .o_data(odata3), .o_src(src3), .o_last(olast3),
    .i_ready(ready)
  );

  always #5 clk = ~clk;

  task automatic set_lanes(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) data[i*DW +: DW] = base + DW'(i);
  endtask

  task automatic push_beat(input int idx);
    sb.push_back({IW'(idx), data[idx*DW +: DW], last[idx]});
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; last = '1; ready = 1'b1; set_lanes(8'hA0);
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (gnt !== '0) begin
        bad++; $display("FAIL reset_gnt cycle=%0d actual=%b required=0000", c, gnt);
      end
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    if ({valid, odata, src, olast} !== '0) begin
      bad++;
      $display("FAIL reset_out actual=v%b d%h s%0d l%b required=v0 d00 s0 l0", valid, odata, src, olast);
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    int eg[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] want;
    req = '1; last = '1; ready = 1'b1; set_lanes(8'hA0);
    for (int c = 0; c < 5; c++) begin
      want = '0; want[eg[c]] = 1'b1;
      #1;
      total++;
      if (gnt !== want) begin
        bad++; $display("FAIL rotation_gnt cycle=%0d actual=%b required=%b", c, gnt, want);
      end
      push_beat(eg[c]);
      @(posedge clk); #1;
      held = sb.pop_front();
      total++;
      if ({valid, src, odata, olast} !== {1'b1, held.src, held.data, held.last}) begin
        bad++;
        $display("FAIL rotation_out cycle=%0d actual=v%b s%0d d%h l%b required=v1 s%0d d%h l%b",
                 c, valid, src, odata, olast, held.src, held.data, held.last);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic rd[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int   eg[6] = '{1, -1, -1, -1, 2, 3};
    logic [N-1:0] want;
    req = '1; last = '1; set_lanes(8'hA0);
    for (int c = 0; c < 6; c++) begin
      ready = rd[c];
      want = '0; if (eg[c] >= 0) want[eg[c]] = 1'b1;
      #1;
      total++;
      if (gnt !== want) begin
        bad++; $display("FAIL backpressure_gnt cycle=%0d actual=%b required=%b", c, gnt, want);
      end
      if (eg[c] >= 0) push_beat(eg[c]);
      @(posedge clk); #1;
      if (sb.size() > 0) held = sb.pop_front();
      total++;
      if ({valid, src, odata, olast} !== {1'b1, held.src, held.data, held.last}) begin
        bad++;
        $display("FAIL backpressure_out cycle=%0d actual=v%b s%0d d%h l%b required=v1 s%0d d%h l%b",
                 c, valid, src, odata, olast, held.src, held.data, held.last);
      end
      @(negedge clk);
    end
    ready = 1'b1;
  endtask

  task automatic test_packet_lock();
    logic [N-1:0] rq[6] = '{4'b0001, 4'b0111, 4'b0111, 4'b0111, 4'b0101, 4'b0001};
    logic [N-1:0] ls[6] = '{4'b1111, 4'b0101, 4'b0101, 4'b0111, 4'b0101, 4'b0101};
    int           eg[6] = '{0, 1, 1, 1, 2, 0};
    logic [N-1:0] want;
    ready = 1'b1; set_lanes(8'hB0);
    for (int c = 0; c < 6; c++) begin
      req = rq[c]; last = ls[c];
      data[1*DW +: DW] = 8'h10 + DW'(c);
      want = '0; want[eg[c]] = 1'b1;
      #1;
      total++;
      if (gnt !== want) begin
        bad++; $display("FAIL packet_gnt cycle=%0d actual=%b required=%b", c, gnt, want);
      end
      push_beat(eg[c]);
      @(posedge clk); #1;
      held = sb.pop_front();
      total++;
      if ({valid, src, odata, olast} !== {1'b1, held.src, held.data, held.last}) begin
        bad++;
        $display("FAIL packet_out cycle=%0d actual=v%b s%0d d%h l%b required=v1 s%0d d%h l%b",
                 c, valid, src, odata, olast, held.src, held.data, held.last);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap_idle();
    logic [N-1:0] rq[3] = '{4'b1000, 4'b1001, 4'b0000};
    int           eg[3] = '{3, 0, -1};
    logic         ev[3] = '{1'b1, 1'b1, 1'b0};
    logic [N-1:0] want;
    ready = 1'b1; last = '1; set_lanes(8'hA0);
    for (int c = 0; c < 3; c++) begin
      req = rq[c];
      want = '0; if (eg[c] >= 0) want[eg[c]] = 1'b1;
      #1;
      total++;
      if (gnt !== want) begin
        bad++; $display("FAIL wrap_gnt cycle=%0d actual=%b required=%b", c, gnt, want);
      end
      if (eg[c] >= 0) push_beat(eg[c]);
      @(posedge clk); #1;
      if (sb.size() > 0) held = sb.pop_front();
      total++;
      if ({valid, src, odata, olast} !== {ev[c], held.src, held.data, held.last}) begin
        bad++;
        $display("FAIL wrap_out cycle=%0d actual=v%b s%0d d%h l%b required=v%b s%0d d%h l%b",
                 c, valid, src, odata, olast, ev[c], held.src, held.data, held.last);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic         rs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [N-1:0] rq[4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0101};
    logic [N-1:0] ls[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0101};
    int           eg[4] = '{2, 2, -1, 0};
    logic         ev[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [N-1:0] want;
    ready = 1'b1; set_lanes(8'hC0);
    for (int c = 0; c < 4; c++) begin
      rst = rs[c]; req = rq[c]; last = ls[c];
      data[2*DW +: DW] = 8'h20 + DW'(c);
      want = '0; if (eg[c] >= 0) want[eg[c]] = 1'b1;
      #1;
      total++;
      if (gnt !== want) begin
        bad++; $display("FAIL rstmid_gnt cycle=%0d actual=%b required=%b", c, gnt, want);
      end
      if (eg[c] >= 0) push_beat(eg[c]);
      @(posedge clk); #1;
      if (rs[c]) held = '0;
      else if (sb.size() > 0) held = sb.pop_front();
      total++;
      if ({valid, src, odata, olast} !== {ev[c], held.src, held.data, held.last}) begin
        bad++;
        $display("FAIL rstmid_out cycle=%0d actual=v%b s%0d d%h l%b required=v%b s%0d d%h l%b",
                 c, valid, src, odata, olast, ev[c], held.src, held.data, held.last);
      end
      @(negedge clk);
    end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_non_pow2();
    int eg[5] = '{0, 1, 2, 0, 1};
    logic [2:0] want;
    ready = 1'b1; req3 = 3'b111; last3 = 3'b111;
    for (int i = 0; i < 3; i++) data3[i*DW +: DW] = 8'h30 + DW'(i);
    for (int c = 0; c < 5; c++) begin
      want = '0; want[eg[c]] = 1'b1;
      #1;
      total++;
      if (gnt3 !== want) begin
        bad++; $display("FAIL n3_gnt cycle=%0d actual=%b required=%b", c, gnt3, want);
      end
      sb.push_back({IW'(eg[c]), data3[eg[c]*DW +: DW], 1'b1});
      @(posedge clk); #1;
      held = sb.pop_front();
      total++;
      if ({valid3, src3, odata3, olast3} !== {1'b1, held.src, held.data, held.last}) begin
        bad++;
        $display("FAIL n3_out cycle=%0d actual=v%b s%0d d%h l%b required=v1 s%0d d%h l%b",
                 c, valid3, src3, odata3, olast3, held.src, held.data, held.last);
      end
      @(negedge clk);
    end
    req3 = '0;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; req = '0; last = '0; data = '0;
    req3 = '0; last3 = '0; data3 = '0;
    held = '0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_packet_lock();
    test_wrap_idle();
    test_reset_mid_packet();
    test_non_pow2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
